// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - multicycle RV32I main control FSM
// Define ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP and add the illegal_instr output.
module multicycle_main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       instr_retire
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);
`ifdef ILLEGAL_TRAP_EN
  localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(11);
`endif

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [STATE_W-1:0] state, state_next;
  logic pc_update, branch, ir_w, mem_w, reg_w, retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_w       = mem_ready;
        pc_update  = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      state_next = S_TRAP;
`else
          default: begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_w      = mem_ready;
        retire     = mem_ready;
        state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w  = 1'b1;
        retire = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: state_next = S_TRAP;
`endif
      default: state_next = S_FETCH;
    endcase
  end

  // Strobes are gated by rst_n so a reset mid-access never leaks a write.
  assign pc_write     = rst_n & (pc_update | (branch & zero));
  assign ir_write     = rst_n & ir_w;
  assign mem_write    = rst_n & mem_w;
  assign reg_write    = rst_n & reg_w;
  assign instr_retire = rst_n & retire;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - randomized bench with per-instruction step-list reference model
module tb_multicycle_main_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, instr_retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic illegal_w;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .instr_retire(instr_retire)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_instr(illegal_w)
`endif
  );
`ifndef ILLEGAL_TRAP_EN
  assign illegal_w = 1'b0;
  localparam bit TRAP_EN = 1'b0;
`else
  localparam bit TRAP_EN = 1'b1;
`endif

  // Abstract instruction steps; an instruction is the list of steps it walks through.
  localparam int S_F = 0, S_D = 1, S_DN = 2, S_MA = 3, S_MR = 4, S_MWB = 5, S_MW = 6;
  localparam int S_ER = 7, S_EI = 8, S_WB = 9, S_BEQ = 10, S_JAL = 11, S_TRAP = 12, S_NONE = -1;

  typedef struct packed {
    logic pc_write; logic adr_src; logic mem_write; logic ir_write;
    logic [1:0] result_src; logic [1:0] alu_src_a; logic [1:0] alu_src_b; logic [1:0] alu_op;
    logic reg_write; logic instr_retire; logic illegal;
  } outs_t;

  int n_cmp = 0, n_bad = 0;
  int model_q[$];
  logic [6:0] cur_op = 7'b0110011;
  logic cur_zero = 1'b0;
  int cur_stall = 0, hold_cnt = 0, prog_idx = 0;
  bit rnd = 1'b0, collect = 1'b0;
  int prog_len = 0;
  logic [6:0] prog_op[16];
  logic prog_zero[16];
  int prog_stall[16];
  int lens[$];
  int cyc = 0;
  outs_t exp_o, act_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 || o == 7'b0010011 ||
           o == 7'b1100011 || o == 7'b1101111;
  endfunction

  function automatic void push_steps(input int a, input int b, input int c, input int d);
    int s[4];
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    for (int i = 0; i < 4; i++) if (s[i] != S_NONE) model_q.push_back(s[i]);
  endfunction

  function automatic void load_body(input logic [6:0] o);
    cur_op = o;
    case (o)
      7'b0000011: push_steps(S_D, S_MA, S_MR, S_MWB);
      7'b0100011: push_steps(S_D, S_MA, S_MW, S_NONE);
      7'b0110011: push_steps(S_D, S_ER, S_WB, S_NONE);
      7'b0010011: push_steps(S_D, S_EI, S_WB, S_NONE);
      7'b1100011: push_steps(S_D, S_BEQ, S_NONE, S_NONE);
      7'b1101111: push_steps(S_D, S_JAL, S_WB, S_NONE);
      default: if (TRAP_EN) push_steps(S_D, S_TRAP, S_NONE, S_NONE);
               else push_steps(S_DN, S_NONE, S_NONE, S_NONE);
    endcase
  endfunction

  function automatic void pick_next();
    logic [6:0] o;
    logic [6:0] table_op[9];
    if (prog_idx < prog_len) begin
      o = prog_op[prog_idx];
      cur_zero = prog_zero[prog_idx];
      cur_stall = prog_stall[prog_idx];
      prog_idx++;
    end else begin
      table_op[0] = 7'b0000011; table_op[1] = 7'b0100011; table_op[2] = 7'b0110011;
      table_op[3] = 7'b0010011; table_op[4] = 7'b1100011; table_op[5] = 7'b1101111;
      table_op[6] = 7'b0110011; table_op[7] = 7'b0000000; table_op[8] = 7'($urandom);
      o = table_op[$urandom_range(0, 8)];
      if (TRAP_EN && !is_legal(o)) o = 7'b0010011;
      cur_zero = 1'($urandom_range(0, 1));
      cur_stall = $urandom_range(0, 2);
    end
    load_body(o);
  endfunction

  function automatic outs_t expect_outs(input int s, input logic mr, input logic z, input logic rn);
    outs_t o;
    o = '0;
    case (s)
      S_F:   begin o.alu_src_b = 2'b10; o.result_src = 2'b10; o.ir_write = mr; o.pc_write = mr; end
      S_D:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
      S_DN:  begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.instr_retire = 1'b1; end
      S_MA:  begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
      S_MR:  o.adr_src = 1'b1;
      S_MWB: begin o.result_src = 2'b01; o.reg_write = 1'b1; o.instr_retire = 1'b1; end
      S_MW:  begin o.adr_src = 1'b1; o.mem_write = mr; o.instr_retire = mr; end
      S_ER:  begin o.alu_src_a = 2'b10; o.alu_op = 2'b10; end
      S_EI:  begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_op = 2'b10; end
      S_WB:  begin o.reg_write = 1'b1; o.instr_retire = 1'b1; end
      S_BEQ: begin o.alu_src_a = 2'b10; o.alu_op = 2'b01; o.pc_write = z; o.instr_retire = 1'b1; end
      S_JAL: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1; end
      S_TRAP: o.illegal = 1'b1;
      default: ;
    endcase
    if (!rn) begin
      o.pc_write = 1'b0; o.ir_write = 1'b0; o.mem_write = 1'b0;
      o.reg_write = 1'b0; o.instr_retire = 1'b0;
    end
    return o;
  endfunction

  // Reference model: advance through the current instruction's step list.
  always @(posedge clk or negedge rst_n) begin : model
    int s;
    if (!rst_n) begin
      model_q.delete();
      model_q.push_back(S_F);
      hold_cnt = 0;
    end else if (model_q.size() != 0) begin
      s = model_q[0];
      if (s == S_TRAP || ((s == S_F || s == S_MR || s == S_MW) && !mem_ready)) begin
        hold_cnt++;
      end else begin
        void'(model_q.pop_front());
        hold_cnt = 0;
        if (s == S_F) pick_next();
        if (model_q.size() == 0) model_q.push_back(S_F);
      end
    end
  end

  always @(negedge clk) begin
    if (model_q.size() != 0) begin
      exp_o = expect_outs(model_q[0], mem_ready, zero, rst_n);
      act_o.pc_write = pc_write;     act_o.adr_src = adr_src;
      act_o.mem_write = mem_write;   act_o.ir_write = ir_write;
      act_o.result_src = result_src; act_o.alu_src_a = alu_src_a;
      act_o.alu_src_b = alu_src_b;   act_o.alu_op = alu_op;
      act_o.reg_write = reg_write;   act_o.instr_retire = instr_retire;
      act_o.illegal = illegal_w;
      chk("outputs", 32'(act_o), 32'(exp_o));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) cyc = 0;
    else begin
      cyc++;
      if (instr_retire) begin
        if (collect) lens.push_back(cyc);
        cyc = 0;
      end
    end
  end

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    op = cur_op;
    if (rnd) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      zero = 1'($urandom_range(0, 1));
    end else begin
      zero = cur_zero;
      mem_ready = ((model_q[0] == S_MR || model_q[0] == S_MW) && hold_cnt < cur_stall) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic add_prog(input logic [6:0] o, input logic z, input int st);
    prog_op[prog_len] = o;
    prog_zero[prog_len] = z;
    prog_stall[prog_len] = st;
    prog_len++;
  endtask

  initial begin
    int exp_len[$];
    bit found;
    add_prog(7'b0110011, 1'b0, 0);
    add_prog(7'b0000011, 1'b0, 2);
    add_prog(7'b1100011, 1'b1, 0);
    add_prog(7'b1100011, 1'b0, 0);
    add_prog(7'b1101111, 1'b0, 0);
    add_prog(7'b0100011, 1'b0, 1);
    add_prog(7'b0010011, 1'b0, 0);
    exp_len = '{4, 7, 3, 3, 4, 5, 4};
    if (!TRAP_EN) begin
      add_prog(7'b0000000, 1'b0, 0);
      exp_len.push_back(2);
    end
    add_prog(7'b0000011, 1'b0, 0);
    exp_len.push_back(5);

    repeat (3) drive_cycle();
    rst_n = 1'b1;
    collect = 1'b1;
    for (int i = 0; i < 200 && lens.size() < exp_len.size(); i++) drive_cycle();
    collect = 1'b0;
    chk("directed_retire_count", 32'(lens.size()), 32'(exp_len.size()));
    for (int i = 0; i < exp_len.size(); i++)
      chk($sformatf("instr%0d_cycles", i), (i < lens.size()) ? 32'(lens[i]) : 32'hffff_ffff,
          32'(exp_len[i]));

    if (TRAP_EN) begin
      add_prog(7'b0000000, 1'b0, 0);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        drive_cycle();
        found = (model_q[0] == S_TRAP);
      end
      chk("trap_reached", 32'(found), 32'd1);
      repeat (10) drive_cycle();
      chk("trap_held", {30'd0, illegal_w, instr_retire}, 32'd2);
      rst_n = 1'b0;
      repeat (2) drive_cycle();
      rst_n = 1'b1;
    end

    add_prog(7'b0100011, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      drive_cycle();
      found = (model_q[0] == S_MW);
    end
    chk("memwrite_reached", 32'(found), 32'd1);
    #1;
    chk("mem_write_before_reset", 32'(mem_write), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("strobes_in_reset", {27'd0, pc_write, ir_write, mem_write, reg_write, instr_retire}, 32'd0);
    repeat (2) drive_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ir_write_after_release", 32'(ir_write), 32'd1);

    rnd = 1'b1;
    repeat (1500) drive_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
